// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences an external PLL: pulses its reset, waits for a stable synchronized
// LOCK indication, declares lock, and tracks lock losses and wait timeouts.
// Everything runs on a free-running clock that is independent of the PLL.
//
// Parameters
//   SYNC_STAGES    flops in the lock_in synchronizer (>= 2)
//   PLLRST_CYCLES  pll_rst pulse length in clk cycles (>= 1)
//   STABLE_CYCLES  consecutive synchronized-lock cycles needed to lock (>= 1)
//   TIMEOUT_CYCLES max WAIT cycles before the PLL is reset again
//                  (> STABLE_CYCLES)
//   LOSS_CNT_W     width of loss_count
//
// Ports
//   clk          in   free-running clock
//   rst          in   synchronous active-high reset
//   lock_in      in   PLL LOCK, asynchronous to clk
//   pll_rst      out  PLL reset, active-high (registered)
//   locked       out  high while the PLL is declared stable (registered)
//   sys_rst      out  downstream reset, always the inverse of locked
//   loss_count   out  saturating count of lock losses
//   timeout_err  out  sticky: a WAIT period has timed out at least once
//   state        out  current FSM state encoding
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | PLLRST : pll_rst held high for PLLRST_CYCLES cycles
//   1   | WAIT   : qualify lock_s for STABLE_CYCLES, bounded by timeout
//   2   | LOCKED : PLL declared stable; any lock_s drop returns to WAIT
//   3   | unused : recovers to PLLRST
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLLRST_CYCLES  = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock_in,
    output logic                  pll_rst,
    output logic                  locked,
    output logic                  sys_rst,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic                  timeout_err,
    output logic [1:0]            state
);

    // Sized to hold TIMEOUT_CYCLES so the wait counter can never wrap.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PR_W  = (PLLRST_CYCLES > 1) ? $clog2(PLLRST_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PR_W-1:0]  PLLRST_LAST  = PR_W'(PLLRST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    logic [PR_W-1:0]  pllrst_cnt;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] wait_cnt;

    logic pllrst_done;
    logic stable_hit;
    logic timeout_hit;
    logic timeout_fire;

    logic pll_rst_nxt;
    logic locked_nxt;

    // -----------------------------------------------------------------------
    // lock_in synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Terminal-count decodes
    // -----------------------------------------------------------------------
    // stable_hit marks the STABLE_CYCLES-th consecutive lock_s=1 cycle.
    assign pllrst_done  = (pllrst_cnt == PLLRST_LAST);
    assign stable_hit   = lock_s && (stable_cnt == STABLE_LAST);
    assign timeout_hit  = (wait_cnt == TIMEOUT_LAST);
    // Qualification wins over timeout when both land on the same cycle.
    assign timeout_fire = (state_q == ST_WAIT) && timeout_hit && !stable_hit;

    // -----------------------------------------------------------------------
    // FSM: state register (outputs registered alongside the state)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PLLRST;
            pll_rst <= 1'b1;
            locked  <= 1'b0;
            sys_rst <= 1'b1;
        end else begin
            state_q <= state_nxt;
            pll_rst <= pll_rst_nxt;
            locked  <= locked_nxt;
            sys_rst <= !locked_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_PLLRST: begin
                if (pllrst_done) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stable_hit) begin
                    state_nxt = ST_LOCKED;
                end else if (timeout_hit) begin
                    state_nxt = ST_PLLRST;
                end
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                end
            end
            default: begin
                state_nxt = ST_PLLRST;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic, decoded from the next state so the registered
    // outputs switch on the same edge as state.
    // -----------------------------------------------------------------------
    always_comb begin
        pll_rst_nxt = 1'b0;
        locked_nxt  = 1'b0;
        case (state_nxt)
            ST_PLLRST: pll_rst_nxt = 1'b1;
            ST_LOCKED: locked_nxt  = 1'b1;
            default: begin
                pll_rst_nxt = 1'b0;
                locked_nxt  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters, loss tracking and sticky timeout flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pllrst_cnt  <= '0;
            stable_cnt  <= '0;
            wait_cnt    <= '0;
            loss_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    // Holding both WAIT counters at zero here means WAIT is
                    // always entered with clean counters.
                    stable_cnt <= '0;
                    wait_cnt   <= '0;
                    if (pllrst_done) begin
                        pllrst_cnt <= '0;
                    end else begin
                        pllrst_cnt <= pllrst_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    pllrst_cnt <= '0;
                    if (state_nxt != ST_WAIT) begin
                        stable_cnt <= '0;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (lock_s) begin
                            stable_cnt <= stable_cnt + 1'b1;
                        end else begin
                            stable_cnt <= '0;
                        end
                    end
                    if (timeout_fire) begin
                        timeout_err <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    pllrst_cnt <= '0;
                    stable_cnt <= '0;
                    wait_cnt   <= '0;
                    if (!lock_s && (loss_count != '1)) begin
                        loss_count <= loss_count + 1'b1;
                    end
                end
                default: begin
                    pllrst_cnt <= '0;
                    stable_cnt <= '0;
                    wait_cnt   <= '0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with small parameters. Expected
// output vectors {state, pll_rst, locked, sys_rst, loss_count, timeout_err}
// are queued with the cycle they apply to and checked on the falling edge.
// Cycle k of a run is the k-th cycle after rst is released (k=0 is the first
// cycle with rst=0). lock_in driven during cycle c reaches lock_s in c+2.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int SYNC_STAGES    = 2;
    localparam int PLLRST_CYCLES  = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int LOSS_CNT_W     = 2;

    localparam logic [1:0] S_PLLRST = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic                  clk     = 1'b0;
    logic                  rst     = 1'b1;
    logic                  lock_in = 1'b0;
    logic                  pll_rst;
    logic                  locked;
    logic                  sys_rst;
    logic [LOSS_CNT_W-1:0] loss_count;
    logic                  timeout_err;
    logic [1:0]            state;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES   (SYNC_STAGES),
        .PLLRST_CYCLES (PLLRST_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LOSS_CNT_W    (LOSS_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lock_in    (lock_in),
        .pll_rst    (pll_rst),
        .locked     (locked),
        .sys_rst    (sys_rst),
        .loss_count (loss_count),
        .timeout_err(timeout_err),
        .state      (state)
    );

    typedef struct {
        int         cyc;
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_rel(input int d, input string tag, input logic [1:0] st,
                              input logic pr, input logic lk,
                              input logic [1:0] lc, input logic te);
        exp_t e;
        e.cyc = cyc + d;
        e.tag = tag;
        e.exp = {st, pr, lk, ~lk, lc, te};
        sb.push_back(e);
    endtask

    task automatic check_now();
        logic [7:0] obs;
        obs = {state, pll_rst, locked, sys_rst, loss_count, timeout_err};
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                assert (obs === sb[i].exp) else begin
                    failures++;
                    $error("FAIL %s cycle=%0d observed st/pr/lk/sr/lc/te=%b expected=%b",
                           sb[i].tag, cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            check_now();
        end
    endtask

    // One-cycle lock_in drop while LOCKED: state leaves LOCKED 3 cycles later,
    // loss_count steps, and relock follows 8 stable cycles.
    task automatic loss_pulse(input string tag, input logic [1:0] lc_old,
                              input logic [1:0] lc_new, input logic te);
        expect_rel(0,  {tag, "_pre"},    S_LOCKED, 1'b0, 1'b1, lc_old, te);
        expect_rel(2,  {tag, "_hold"},   S_LOCKED, 1'b0, 1'b1, lc_old, te);
        expect_rel(3,  {tag, "_drop"},   S_WAIT,   1'b0, 1'b0, lc_new, te);
        expect_rel(10, {tag, "_wait"},   S_WAIT,   1'b0, 1'b0, lc_new, te);
        expect_rel(11, {tag, "_relock"}, S_LOCKED, 1'b0, 1'b1, lc_new, te);
        check_now();
        lock_in = 1'b0;
        tick(1);
        lock_in = 1'b1;
        tick(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        lock_in = 1'b1;
        tick(1);

        // Reset held for several cycles: PLLRST pulse does not advance.
        for (int k = 0; k <= 2; k++)
            expect_rel(k, "reset_state", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        check_now();
        tick(2);

        // Run A: lock_in constantly high.
        rst = 1'b0;
        for (int k = 0; k <= 3; k++)
            expect_rel(k, "a_pllrst", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        for (int k = 4; k <= 11; k++)
            expect_rel(k, "a_wait", S_WAIT, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int k = 12; k <= 14; k++)
            expect_rel(k, "a_locked", S_LOCKED, 1'b0, 1'b1, 2'd0, 1'b0);
        check_now();
        tick(14);

        loss_pulse("a_loss1", 2'd0, 2'd1, 1'b0);
        loss_pulse("a_loss2", 2'd1, 2'd2, 1'b0);

        // One-cycle rst while LOCKED with loss_count=2.
        expect_rel(0, "a_rst_before", S_LOCKED, 1'b0, 1'b1, 2'd2, 1'b0);
        expect_rel(1, "a_rst_edge",   S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        check_now();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // Run C: one-cycle lock_in glitch during WAIT restarts qualification.
        for (int k = 0; k <= 3; k++)
            expect_rel(k, "c_pllrst", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_rel(4,  "c_wait_entry",    S_WAIT,   1'b0, 1'b0, 2'd0, 1'b0);
        expect_rel(12, "c_no_early_lock", S_WAIT,   1'b0, 1'b0, 2'd0, 1'b0);
        expect_rel(16, "c_wait_last",     S_WAIT,   1'b0, 1'b0, 2'd0, 1'b0);
        expect_rel(17, "c_locked",        S_LOCKED, 1'b0, 1'b1, 2'd0, 1'b0);
        check_now();
        tick(6);
        lock_in = 1'b0;
        tick(1);
        lock_in = 1'b1;
        tick(10);

        // Run B: lock_in low -> repeated timeouts, then a same-cycle
        // qualify/timeout collision, then five lock losses.
        expect_rel(1, "b_reset", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_rel(2, "b_reset", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        check_now();
        rst     = 1'b1;
        lock_in = 1'b0;
        tick(2);
        rst = 1'b0;
        expect_rel(3,   "b_pllrst_end",  S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_rel(4,   "b_wait1_start", S_WAIT,   1'b0, 1'b0, 2'd0, 1'b0);
        expect_rel(67,  "b_wait1_last",  S_WAIT,   1'b0, 1'b0, 2'd0, 1'b0);
        expect_rel(68,  "b_timeout1",    S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_rel(71,  "b_pllrst2_end", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_rel(72,  "b_wait2_start", S_WAIT,   1'b0, 1'b0, 2'd0, 1'b1);
        expect_rel(135, "b_wait2_last",  S_WAIT,   1'b0, 1'b0, 2'd0, 1'b1);
        expect_rel(136, "b_timeout2",    S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_rel(139, "b_pllrst3_end", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_rel(140, "b_wait3_start", S_WAIT,   1'b0, 1'b0, 2'd0, 1'b1);
        expect_rel(203, "b_wait3_last",  S_WAIT,   1'b0, 1'b0, 2'd0, 1'b1);
        expect_rel(204, "b_lock_prio",   S_LOCKED, 1'b0, 1'b1, 2'd0, 1'b1);
        check_now();
        // lock_s rises in WAIT cycle 56 of the third window, so qualification
        // completes on the 64th WAIT cycle, the same cycle as the timeout.
        tick(194);
        lock_in = 1'b1;
        tick(10);

        loss_pulse("b_loss1", 2'd0, 2'd1, 1'b1);
        loss_pulse("b_loss2", 2'd1, 2'd2, 1'b1);
        loss_pulse("b_loss3", 2'd2, 2'd3, 1'b1);
        loss_pulse("b_loss4", 2'd3, 2'd3, 1'b1);
        loss_pulse("b_loss5", 2'd3, 2'd3, 1'b1);

        // Reset clears the sticky flag and the saturated loss count.
        expect_rel(1, "b_rst_clears", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        check_now();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_rel(3, "d_pllrst_end", S_PLLRST, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_rel(4, "d_wait_entry", S_WAIT,   1'b0, 1'b0, 2'd0, 1'b0);
        check_now();
        tick(4);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
